// File: rtl/sha256_pkg.sv
// SHA-256 constants, helper functions and FSM encoding
// shared by the stream core and its round datapath.
package sha256_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_FINAL,
    S_DBL_LOAD
  } state_e;

  localparam logic [31:0] DBL_PAD_HI  = 32'h80000000;
  localparam logic [31:0] DBL_PAD_LEN = 32'h00000100;

  // K[63] holds K0 so the concatenation reads in round order
  localparam logic [63:0][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // IV[7] is H0 so a 256-bit view matches digest byte order
  localparam logic [7:0][31:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] k_at(logic [5:0] t);
    return K[6'd63 - t];
  endfunction

  function automatic logic [31:0] rotr(
    logic [31:0] x,
    int          n
  );
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(
    logic [31:0] e,
    logic [31:0] f,
    logic [31:0] g
  );
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(
    logic [31:0] a,
    logic [31:0] b,
    logic [31:0] c
  );
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_stream_if.sv
// Block stream into the core and digest out of it.
// master = padder side, slave = hashing core.
interface sha256_stream_if;
  logic [511:0] blk;
  logic         blk_valid;
  logic         blk_ready;
  logic         blk_first;
  logic         blk_last;
  logic         dbl;
  logic [255:0] hash;
  logic         hash_valid;
  logic         busy;

  modport master (
    output blk, blk_valid, blk_first, blk_last, dbl,
    input  blk_ready, hash, hash_valid, busy
  );

  modport slave (
    input  blk, blk_valid, blk_first, blk_last, dbl,
    output blk_ready, hash, hash_valid, busy
  );
endinterface

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round.
// Chained UNROLL deep inside the stream core.
module sha256_round
  import sha256_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] c_i,
  input  logic [31:0] d_i,
  input  logic [31:0] e_i,
  input  logic [31:0] f_i,
  input  logic [31:0] g_i,
  input  logic [31:0] h_i,
  input  logic [31:0] w_i,
  input  logic [31:0] k_i,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [31:0] c_o,
  output logic [31:0] d_o,
  output logic [31:0] e_o,
  output logic [31:0] f_o,
  output logic [31:0] g_o,
  output logic [31:0] h_o
);

  logic [31:0] t1;
  logic [31:0] t2;

  assign t1 = h_i + bsig1(e_i) + ch(e_i, f_i, g_i)
            + k_i + w_i;
  assign t2 = bsig0(a_i) + maj(a_i, b_i, c_i);

  assign a_o = t1 + t2;
  assign b_o = a_i;
  assign c_o = b_i;
  assign d_o = c_i;
  assign e_o = d_i + t1;
  assign f_o = e_i;
  assign g_o = f_i;
  assign h_o = g_i;

endmodule

// File: rtl/sha256_stream_core.sv
// Iterative multi-block SHA-256 with block handshake,
// rounds-per-cycle unroll and optional double hash.
module sha256_stream_core
  import sha256_pkg::*;
#(
  parameter int UNROLL = 1,
  parameter int DBL_EN = 1
) (
  input logic             CLK,
  input logic             nreset,
  sha256_stream_if.slave  s
);

  if (!(UNROLL == 1 || UNROLL == 2 ||
        UNROLL == 4 || UNROLL == 8)) begin : g_bad
    $error("sha256_stream_core: UNROLL must be 1, 2, 4 or 8");
  end

  localparam logic       DBL_ON = (DBL_EN != 0);
  localparam logic [5:0] STEP   = 6'(UNROLL);
  localparam logic [5:0] CNT_END = 6'(64 - UNROLL);

  state_e state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [15:0][31:0] w_q, w_d;
  logic [7:0][31:0]  v_q, v_d;
  logic [7:0][31:0]  h_q, h_d;
  logic              last_q, last_d;
  logic              dbl_q, dbl_d;
  logic [255:0]      hash_q, hash_d;
  logic              hv_q, hv_d;
  logic              busy_q, busy_d;

  logic [15:0][31:0] w_rnd;
  logic [7:0][31:0]  v_rnd;
  logic [7:0][31:0]  h_sum;

  // w[15] is the current W_t, w[0] the newest word; v[7] is a
  for (genvar i = 0; i < UNROLL; i++) begin : g_rnd
    logic [7:0][31:0]  vin;
    logic [7:0][31:0]  vout;
    logic [15:0][31:0] win;
    logic [15:0][31:0] wout;
    logic [31:0]       nw;

    if (i == 0) begin : g_head
      assign vin = v_q;
      assign win = w_q;
    end else begin : g_link
      assign vin = g_rnd[i-1].vout;
      assign win = g_rnd[i-1].wout;
    end

    assign nw = ssig1(win[1]) + win[6]
              + ssig0(win[14]) + win[15];
    assign wout = {win[14:0], nw};

    sha256_round u_rnd (
      .a_i (vin[7]),
      .b_i (vin[6]),
      .c_i (vin[5]),
      .d_i (vin[4]),
      .e_i (vin[3]),
      .f_i (vin[2]),
      .g_i (vin[1]),
      .h_i (vin[0]),
      .w_i (win[15]),
      .k_i (k_at(cnt_q + 6'(i))),
      .a_o (vout[7]),
      .b_o (vout[6]),
      .c_o (vout[5]),
      .d_o (vout[4]),
      .e_o (vout[3]),
      .f_o (vout[2]),
      .g_o (vout[1]),
      .h_o (vout[0])
    );
  end

  assign v_rnd = g_rnd[UNROLL-1].vout;
  assign w_rnd = g_rnd[UNROLL-1].wout;

  // chaining value plus working vars, word-wise mod 2^32
  always_comb begin
    h_sum = '0;
    for (int i = 0; i < 8; i++) begin
      h_sum[i] = h_q[i] + v_q[i];
    end
  end

  // next-state and datapath control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    v_d     = v_q;
    h_d     = h_q;
    last_d  = last_q;
    dbl_d   = dbl_q;
    hash_d  = hash_q;
    hv_d    = 1'b0;
    busy_d  = busy_q;
    unique case (state_q)
      S_IDLE: begin
        if (s.blk_valid) begin
          w_d     = s.blk;
          last_d  = s.blk_last;
          dbl_d   = s.dbl & DBL_ON;
          cnt_d   = '0;
          state_d = S_ROUND;
          if (s.blk_first) begin
            v_d    = IV;
            h_d    = IV;
            busy_d = 1'b1;
          end else begin
            v_d = h_q;
          end
        end
      end
      S_ROUND: begin
        w_d   = w_rnd;
        v_d   = v_rnd;
        cnt_d = cnt_q + STEP;
        if (cnt_q == CNT_END) begin
          state_d = S_FINAL;
        end
      end
      S_FINAL: begin
        h_d = h_sum;
        if (!last_q) begin
          state_d = S_IDLE;
        end else if (dbl_q) begin
          state_d = S_DBL_LOAD;
        end else begin
          hash_d  = h_sum;
          hv_d    = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_DBL_LOAD: begin
        w_d     = {h_q, DBL_PAD_HI, 192'h0, DBL_PAD_LEN};
        v_d     = IV;
        h_d     = IV;
        dbl_d   = 1'b0;
        last_d  = 1'b1;
        cnt_d   = '0;
        state_d = S_ROUND;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state registers
  always_ff @(posedge CLK or negedge nreset) begin
    if (!nreset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      w_q     <= '0;
      v_q     <= '0;
      h_q     <= IV;
      last_q  <= 1'b0;
      dbl_q   <= 1'b0;
      hash_q  <= '0;
      hv_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      v_q     <= v_d;
      h_q     <= h_d;
      last_q  <= last_d;
      dbl_q   <= dbl_d;
      hash_q  <= hash_d;
      hv_q    <= hv_d;
      busy_q  <= busy_d;
    end
  end

  assign s.blk_ready  = (state_q == S_IDLE) & nreset;
  assign s.hash       = hash_q;
  assign s.hash_valid = hv_q;
  assign s.busy       = busy_q;

endmodule

// File: tb/tb_sha256_stream_core.sv
// Directed-vector bench for sha256_stream_core with one
// instance per legal UNROLL sharing clock, reset and data.
module tb_sha256_stream_core;

  localparam logic [511:0] ABC =
    {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] B1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] B2 = {480'h0, 32'h000001c0};

  localparam logic [255:0] H_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] H_2BLK =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] H_DBL =
    256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358;
  localparam logic [255:0] H_EMPTY =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [511:0]      blk_r;
  logic              first_r;
  logic              last_r;
  logic              dbl_r;
  logic [3:0]        vld;
  logic [3:0]        rdy;
  logic [3:0]        hv;
  logic [3:0]        bsy;
  logic [3:0][255:0] hsh;

  int n_chk  = 0;
  int n_pass = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sha256_stream_if ifc ();
    assign ifc.blk       = blk_r;
    assign ifc.blk_valid = vld[g];
    assign ifc.blk_first = first_r;
    assign ifc.blk_last  = last_r;
    assign ifc.dbl       = dbl_r;
    assign rdy[g]        = ifc.blk_ready;
    assign hv[g]         = ifc.hash_valid;
    assign bsy[g]        = ifc.busy;
    assign hsh[g]        = ifc.hash;

    sha256_stream_core #(
      .UNROLL (1 << g),
      .DBL_EN (1)
    ) dut (
      .CLK    (clk),
      .nreset (rst_n),
      .s      (ifc)
    );
  end

  task automatic chk(
    string        tag,
    logic [255:0] got,
    logic [255:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // present a block, wait (bounded) for ready, leave #1 after accept
  task automatic send(
    int           g,
    logic [511:0] b,
    logic         f,
    logic         l,
    logic         d
  );
    int n;
    n = 0;
    while (!rdy[g] && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", 256'(rdy[g]), 256'd1);
    blk_r   = b;
    first_r = f;
    last_r  = l;
    dbl_r   = d;
    vld[g]  = 1'b1;
    @(posedge clk);
    #1;
    vld[g] = 1'b0;
  endtask

  // cycles from accept edge to hash_valid; -1 if it never comes
  task automatic wait_hv(
    int        g,
    output int lat,
    output int rdy_hi
  );
    lat    = -1;
    rdy_hi = 0;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk);
      #1;
      if (hv[g]) begin
        lat = c;
        break;
      end
      if (rdy[g]) rdy_hi++;
    end
  endtask

  task automatic run_msg(
    int           g,
    logic [511:0] b,
    logic         f,
    logic         d,
    int           exp_lat,
    logic [255:0] exp_h,
    string        tag
  );
    int lat;
    int rh;
    send(g, b, f, 1'b1, d);
    chk({tag, "_busy"}, 256'(bsy[g]), 256'd1);
    chk({tag, "_rdy_drop"}, 256'(rdy[g]), 256'd0);
    wait_hv(g, lat, rh);
    chk({tag, "_lat"}, 256'(lat), 256'(exp_lat));
    chk({tag, "_rdy_low"}, 256'(rh), 256'd0);
    chk({tag, "_hash"}, hsh[g], exp_h);
    chk({tag, "_busy_clr"}, 256'(bsy[g]), 256'd0);
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, 256'(hv[g]), 256'd0);
    chk({tag, "_hold"}, hsh[g], exp_h);
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int rh;
    int cnt_hv;
    int cnt_rdy;
    vld     = '0;
    blk_r   = '0;
    first_r = 1'b0;
    last_r  = 1'b0;
    dbl_r   = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_hash", hsh[0], 256'd0);
    chk("rst_hv", 256'(hv[0]), 256'd0);
    chk("rst_busy", 256'(bsy[0]), 256'd0);
    chk("rst_ready", 256'(rdy[0]), 256'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", 256'(rdy[0]), 256'd1);

    run_msg(0, ABC, 1'b1, 1'b0, 65, H_ABC, "abc");

    // first block of two: no digest, ready low while hashing
    send(0, B1, 1'b1, 1'b0, 1'b0);
    cnt_hv  = 0;
    cnt_rdy = 0;
    for (int c = 1; c <= 65; c++) begin
      @(posedge clk);
      #1;
      if (hv[0]) cnt_hv++;
      if (c <= 64 && rdy[0]) cnt_rdy++;
    end
    chk("blk1_no_hv", 256'(cnt_hv), 256'd0);
    chk("blk1_rdy_low", 256'(cnt_rdy), 256'd0);
    chk("blk1_busy", 256'(bsy[0]), 256'd1);
    chk("blk1_hash_kept", hsh[0], H_ABC);
    @(negedge clk);
    run_msg(0, B2, 1'b0, 1'b0, 65, H_2BLK, "blk2");

    run_msg(0, ABC, 1'b1, 1'b1, 131, H_DBL, "dbl");

    for (int g = 0; g < 4; g++) begin
      run_msg(g, EMPTY, 1'b1, 1'b0, (64 >> g) + 1,
              H_EMPTY, $sformatf("empty_u%0d", 1 << g));
    end

    // reset in the middle of block 1 rounds
    send(0, B1, 1'b1, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk("mid_rst_hash", hsh[0], 256'd0);
    chk("mid_rst_busy", 256'(bsy[0]), 256'd0);
    chk("mid_rst_ready", 256'(rdy[0]), 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt_hv = 0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk);
      #1;
      if (hv[0]) cnt_hv++;
    end
    chk("mid_rst_no_hv", 256'(cnt_hv), 256'd0);
    chk("mid_rst_ready_back", 256'(rdy[0]), 256'd1);
    @(negedge clk);
    run_msg(0, ABC, 1'b1, 1'b0, 65, H_ABC, "post_rst");

    // valid held through processing, then a back-to-back message
    blk_r   = ABC;
    first_r = 1'b1;
    last_r  = 1'b1;
    dbl_r   = 1'b0;
    vld[0]  = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_busy", 256'(bsy[0]), 256'd1);
    wait_hv(0, lat, rh);
    chk("hold_lat", 256'(lat), 256'd65);
    chk("hold_rdy_low", 256'(rh), 256'd0);
    chk("hold_hash", hsh[0], H_ABC);
    blk_r = EMPTY;
    @(posedge clk);
    #1;
    vld[0] = 1'b0;
    chk("b2b_pulse", 256'(hv[0]), 256'd0);
    chk("b2b_busy", 256'(bsy[0]), 256'd1);
    chk("b2b_rdy", 256'(rdy[0]), 256'd0);
    wait_hv(0, lat, rh);
    chk("b2b_lat", 256'(lat), 256'd65);
    chk("b2b_hash", hsh[0], H_EMPTY);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
